// File: rtl/power_pkg.sv
// Shared widths, FSM state encoding and small helpers for the power accumulator.
package power_pkg;

  localparam int IQ_W         = 16;
  localparam int PWR_W        = 32;
  localparam int ACC_W        = 40;
  localparam int AVG_LOG2_MAX = 8;
  localparam int LOG2_W       = 4;
  // Wide enough to hold the largest window length, 2^AVG_LOG2_MAX = 256.
  localparam int CNT_W        = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no window open
    ST_ACCUM = 2'd1,  // window open, counting samples
    ST_DUMP  = 2'd2   // final sum in flight to the output register
  } state_t;

  // Sideband that travels with each sample through the squaring pipeline.
  typedef struct packed {
    logic              first;  // sample opens a window: restart the sum
    logic              last;   // sample closes a window: dump the sum
    logic [LOG2_W-1:0] shift;  // window exponent latched for this window
  } tag_t;

  // Exponents above the maximum are treated as the maximum.
  function automatic logic [LOG2_W-1:0] clamp_log2(input logic [LOG2_W-1:0] v);
    return (v > LOG2_W'(AVG_LOG2_MAX)) ? LOG2_W'(AVG_LOG2_MAX) : v;
  endfunction

  // Number of samples in a window for a (clamped) exponent.
  function automatic logic [CNT_W-1:0] window_len(input logic [LOG2_W-1:0] s);
    return CNT_W'(1) << s;
  endfunction

endpackage

// File: rtl/iq_square_sum.sv
// Two-stage I^2 + Q^2 pipeline: registered products, then registered sum.
// The sum of two squared 16-bit samples is at most 2^31, so 32 unsigned bits
// hold it exactly.
module iq_square_sum
  import power_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   valid_in,
  input  logic signed [IQ_W-1:0] i_data,
  input  logic signed [IQ_W-1:0] q_data,
  output logic                   valid_out,
  output logic [PWR_W-1:0]       sum
);

  logic signed [2*IQ_W-1:0] i_ext;
  logic signed [2*IQ_W-1:0] q_ext;
  logic signed [2*IQ_W-1:0] prod_i;
  logic signed [2*IQ_W-1:0] prod_q;
  logic                     prod_valid;

  // Sign-extend before multiplying so the product is formed at full width.
  assign i_ext = (2*IQ_W)'(i_data);
  assign q_ext = (2*IQ_W)'(q_data);

  // Stage 1: register both squares; flush drops the sample entering the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_i     <= '0;
      prod_q     <= '0;
      prod_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so the stages shift cleanly regardless of order.
      prod_valid <= valid_in && !flush;
      if (valid_in) begin
        prod_i <= i_ext * i_ext;
        prod_q <= q_ext * q_ext;
      end
    end
  end

  // Stage 2: register the sum of squares; squares are never negative.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= prod_valid && !flush;
      if (prod_valid) begin
        sum <= $unsigned(prod_i) + $unsigned(prod_q);
      end
    end
  end

endmodule

// File: rtl/power_accumulator.sv
// Averages I^2 + Q^2 over windows of 2^avg_log2 valid samples.
// Pipeline: capture/square (edge 1), sum (edge 2), accumulate (edge 3),
// shift into the output register (edge 4), i.e. valid_out appears on the
// third edge after the one that captured a window's last sample.
module power_accumulator
  import power_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic signed [IQ_W-1:0]  i_data,
  input  logic signed [IQ_W-1:0]  q_data,
  input  logic [LOG2_W-1:0]       avg_log2,
  input  logic                    clear,
  output logic                    valid_out,
  output logic [PWR_W-1:0]        power
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LOG2_W-1:0] shift_q, shift_d;
  tag_t              tag_in, tag_s1, tag_s2;

  logic [LOG2_W-1:0] new_shift;
  logic              sq_valid;
  logic [PWR_W-1:0]  sq_sum;

  logic [ACC_W-1:0]  acc_q;
  logic              dump_q;
  logic [LOG2_W-1:0] dump_shift_q;

  assign new_shift = clamp_log2(avg_log2);

  // Control FSM, sample counter and window exponent registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // Next state, counter and per-sample tag; a sample taken in IDLE or DUMP
  // opens a new window and latches the exponent, so windows run back-to-back.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves one unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tag_in  = '0;
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (valid_in) begin
      case (state_q)
        ST_ACCUM: begin
          tag_in.shift = shift_q;
          tag_in.last  = ((cnt_q + CNT_W'(1)) == window_len(shift_q));
          if (tag_in.last) begin
            state_d = ST_DUMP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          // A one-sample window closes on the sample that opens it.
          shift_d      = new_shift;
          tag_in.first = 1'b1;
          tag_in.shift = new_shift;
          tag_in.last  = (new_shift == '0);
          if (tag_in.last) begin
            state_d = ST_DUMP;
            cnt_d   = '0;
          end else begin
            state_d = ST_ACCUM;
            cnt_d   = CNT_W'(1);
          end
        end
      endcase
    end else if (state_q == ST_DUMP) begin
      state_d = ST_IDLE;
    end
  end

  iq_square_sum u_square (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clear),
    .valid_in  (valid_in),
    .i_data    (i_data),
    .q_data    (q_data),
    .valid_out (sq_valid),
    .sum       (sq_sum)
  );

  // Delay the window tags to line up with the two-stage squaring pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_s1 <= '0;
      tag_s2 <= '0;
    end else begin
      tag_s1 <= tag_in;
      tag_s2 <= tag_s1;
    end
  end

  // Accumulate squares; the first sample of a window replaces the old sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      dump_q       <= 1'b0;
      dump_shift_q <= '0;
    end else if (clear) begin
      acc_q  <= '0;
      dump_q <= 1'b0;
    end else begin
      dump_q <= sq_valid && tag_s2.last;
      if (sq_valid) begin
        acc_q <= tag_s2.first ? ACC_W'(sq_sum) : acc_q + ACC_W'(sq_sum);
        if (tag_s2.last) begin
          dump_shift_q <= tag_s2.shift;
        end
      end
    end
  end

  // Output register: mean = sum >> exponent; the result always fits 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      power     <= '0;
    end else begin
      valid_out <= dump_q && !clear;
      if (dump_q && !clear) begin
        power <= PWR_W'(acc_q >> dump_shift_q);
      end
    end
  end

endmodule

// File: tb/tb_power_accumulator.sv
// Directed bench for power_accumulator: single-sample vector table followed
// by multi-cycle window, gap, clear and reset sequences.
`timescale 1ns/1ps
module tb_power_accumulator;

  logic               clk;
  logic               rst_n;
  logic               valid_in;
  logic signed [15:0] i_data;
  logic signed [15:0] q_data;
  logic [3:0]         avg_log2;
  logic               clear;
  logic               valid_out;
  logic [31:0]        power;

  int          total;
  int          bad;
  logic [31:0] model_power;
  logic [31:0] pulses[$];

  typedef struct {
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic [31:0]        exp_power;
  } vec_t;

  vec_t vecs[8];

  power_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .i_data    (i_data),
    .q_data    (q_data),
    .avg_log2  (avg_log2),
    .clear     (clear),
    .valid_out (valid_out),
    .power     (power)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record the value of every output pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && valid_out) pulses.push_back(power);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  // Continuous stream of n identical samples; checks valid_out and power
  // every cycle against the window model (pulse 3 cycles after each N-th).
  task automatic run_stream(input string name, input int n, input logic [3:0] lg,
                            input logic signed [15:0] i, input logic signed [15:0] q,
                            input logic [31:0] exp);
    int  win;
    int  eff;
    bit  exp_v;
    eff = (lg > 4'd8) ? 8 : int'(lg);
    win = 1 << eff;
    avg_log2 = lg;
    i_data   = i;
    q_data   = q;
    for (int c = 1; c <= n + 4; c++) begin
      valid_in = (c <= n);
      step();
      exp_v = (c - 3 >= win) && (((c - 3) % win) == 0) && (c - 3 <= n);
      if (exp_v) model_power = exp;
      check($sformatf("%s valid_out c=%0d", name, c), 64'(valid_out), 64'(exp_v));
      check($sformatf("%s power c=%0d", name, c), 64'(power), 64'(model_power));
    end
    valid_in = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_power = '0;

    vecs[0] = '{16'sd3,      16'sd4,      32'd25};
    vecs[1] = '{-16'sd3,     -16'sd4,     32'd25};
    vecs[2] = '{16'sd1000,   16'sd0,      32'd1000000};
    vecs[3] = '{-16'sd32768, -16'sd32768, 32'd2147483648};
    vecs[4] = '{16'sd32767,  16'sd32767,  32'd2147352578};
    vecs[5] = '{16'sd32767,  -16'sd32768, 32'd2147418113};
    vecs[6] = '{16'sd0,      16'sd0,      32'd0};
    vecs[7] = '{-16'sd1,     16'sd1,      32'd2};

    // Reset state.
    rst_n = 1'b0; valid_in = 1'b0; clear = 1'b0;
    i_data = '0; q_data = '0; avg_log2 = '0;
    step(); step();
    check("reset valid_out", 64'(valid_out), 64'd0);
    check("reset power", 64'(power), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Single-sample windows (avg_log2=0): latency 3, one-cycle pulse, hold.
    avg_log2 = 4'd0;
    for (int v = 0; v < 8; v++) begin
      i_data = vecs[v].i; q_data = vecs[v].q; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      step(); step();
      check($sformatf("vec%0d early valid_out", v), 64'(valid_out), 64'd0);
      check($sformatf("vec%0d early power", v), 64'(power), 64'(model_power));
      step();
      model_power = vecs[v].exp_power;
      check($sformatf("vec%0d valid_out", v), 64'(valid_out), 64'd1);
      check($sformatf("vec%0d power", v), 64'(power), 64'(model_power));
      step();
      check($sformatf("vec%0d drop valid_out", v), 64'(valid_out), 64'd0);
      check($sformatf("vec%0d hold power", v), 64'(power), 64'(model_power));
    end
    idle(3);

    // Streams: one output per cycle, window of 4, full scale N=256, clamp.
    run_stream("n1_stream", 10, 4'd0, 16'sd3, 16'sd4, 32'd25);
    idle(3);
    run_stream("n4_stream", 12, 4'd2, 16'sd1000, 16'sd0, 32'd1000000);
    idle(3);
    run_stream("full_scale", 256, 4'd8, -16'sd32768, -16'sd32768, 32'h8000_0000);
    idle(3);
    run_stream("clamp", 256, 4'd12, 16'sd100, -16'sd200, 32'd50000);
    idle(3);

    // Gaps in valid_in pause the window: (1+4)>>1 = 2, one pulse.
    pulses.delete();
    avg_log2 = 4'd1;
    i_data = 16'sd1; q_data = 16'sd0; valid_in = 1'b1;
    step();
    idle(5);
    i_data = 16'sd2; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step(); step();
    check("gap early valid_out", 64'(valid_out), 64'd0);
    step();
    model_power = 32'd2;
    check("gap valid_out", 64'(valid_out), 64'd1);
    check("gap power", 64'(power), 64'd2);
    idle(4);
    check("gap pulse count", 64'(pulses.size()), 64'd1);

    // Clear aborts after 5 of 8 samples; a sample alongside clear is dropped.
    pulses.delete();
    avg_log2 = 4'd3;
    i_data = 16'sd7; q_data = 16'sd7; valid_in = 1'b1;
    for (int k = 0; k < 5; k++) step();
    i_data = 16'sd100; q_data = 16'sd100; clear = 1'b1;
    step();
    clear = 1'b0; valid_in = 1'b0;
    idle(6);
    check("clear no pulse", 64'(pulses.size()), 64'd0);
    check("clear power held", 64'(power), 64'(model_power));
    run_stream("after_clear", 8, 4'd3, 16'sd10, 16'sd10, 32'd200);
    idle(2);
    check("after_clear pulse count", 64'(pulses.size()), 64'd1);

    // Reset after 3 of 4 samples discards the window and zeroes power.
    pulses.delete();
    avg_log2 = 4'd2;
    i_data = 16'sd9; q_data = 16'sd9; valid_in = 1'b1;
    for (int k = 0; k < 3; k++) step();
    valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_power = '0;
    check("midrst valid_out", 64'(valid_out), 64'd0);
    check("midrst power", 64'(power), 64'd0);
    step(); step();
    rst_n = 1'b1;
    idle(6);
    check("midrst no pulse", 64'(pulses.size()), 64'd0);
    check("midrst power after", 64'(power), 64'd0);
    run_stream("post_rst", 4, 4'd2, 16'sd5, 16'sd0, 32'd25);
    idle(3);

    // avg_log2 2->1 mid-window: window 1 = (1+4+9+16)>>2 = 7,
    // window 2 latches 1: (25+36)>>1 = 30.
    pulses.delete();
    q_data = 16'sd0;
    for (int c = 1; c <= 10; c++) begin
      valid_in = (c <= 6);
      i_data   = 16'(c);
      avg_log2 = (c <= 2) ? 4'd2 : 4'd1;
      step();
    end
    valid_in = 1'b0;
    idle(2);
    check("change pulse count", 64'(pulses.size()), 64'd2);
    if (pulses.size() == 2) begin
      check("change window1 power", 64'(pulses[0]), 64'd7);
      check("change window2 power", 64'(pulses[1]), 64'd30);
    end
    check("change final power", 64'(power), 64'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/power_accumulator.md
POWER_ACCUMULATOR -- requirements
Module: power_accumulator

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 valid_in  input  1  qualifies i_data/q_data for one sample per cycle.
REQ-005 i_data  input  16  signed two's-complement in-phase sample.
REQ-006 q_data  input  16  signed two's-complement quadrature sample.
REQ-007 avg_log2  input  4  averaging window exponent; window N = 2^avg_log2 samples.
REQ-008 clear  input  1  synchronous abort of the current window.
REQ-009 valid_out  output  1  one-cycle pulse marking a new power value; feeds the log/dBm stage valid_in.
REQ-010 power  output  32  unsigned mean of I^2+Q^2 over the window; feeds the log/dBm stage power input.

Function
REQ-011 Per valid sample, the block SHALL compute the exact product I*I + Q*Q as an unsigned value of at most 2^31; it SHALL NOT truncate.
REQ-012 The accumulator SHALL be 40 bits wide, which SHALL prevent overflow for N <= 256 at full-scale input.
REQ-013 avg_log2 values above 8 SHALL be treated as 8.
REQ-014 avg_log2 SHALL be latched on the first valid sample of each window; changes mid-window SHALL take effect only from the next window.
REQ-015 A sample counter SHALL advance only on valid_in=1; gaps in valid_in SHALL pause the window without loss or duplication.
REQ-016 When the N-th sample of a window is captured, the block SHALL compute power = accumulated sum >> latched avg_log2, truncating toward zero to the low 32 bits, which always fit.
REQ-017 Latency: valid_out SHALL assert at the 3rd rising edge after the edge that captured the window's last sample; power SHALL update on the same edge.
REQ-018 valid_out SHALL be high for exactly one cycle per completed window; power SHALL hold its value between pulses.
REQ-019 Windows SHALL be back-to-back: when the last sample of one window and the first sample of the next arrive on consecutive cycles, the new window SHALL start from that sample's value without a bubble and without adding to the old sum.
REQ-020 avg_log2=0 SHALL produce one output per valid sample, each at 3-cycle latency, sustaining one output per cycle.
REQ-021 Control FSM states SHALL be:
  - IDLE: no window open.
  - ACCUM: window open, counting.
  - DUMP: final sum in flight to the output register.
REQ-022 FSM transitions SHALL be:
  - IDLE->ACCUM on valid_in.
  - ACCUM->DUMP on the N-th sample.
  - DUMP->ACCUM if valid_in, else DUMP->IDLE.
REQ-023 clear=1 SHALL:
  - zero the counter and accumulator;
  - discard pipeline samples in flight;
  - return the FSM to IDLE;
  - suppress valid_out for the aborted window;
  - leave power unchanged.
REQ-024 valid_in asserted in the same cycle as clear SHALL be discarded; the next window SHALL start at the first valid sample after clear deasserts.

Reset
REQ-025 While rst_n=0, the block SHALL hold:
  - valid_out=0;
  - power=32'd0;
  - counter, accumulator and all pipeline valids at 0;
  - FSM in IDLE.
REQ-026 Reset asserted mid-window SHALL discard the partial window with no valid_out; after release, the first valid sample SHALL open a fresh window.

Structure
REQ-027 Package power_pkg SHALL hold:
  - IQ_W=16, PWR_W=32, ACC_W=40, AVG_LOG2_MAX=8;
  - the FSM state enumeration.
REQ-028 The squaring stage SHALL be a sub-module iq_square_sum:
  - two registered signed multipliers plus a registered adder;
  - 2-cycle latency with a valid pass-through;
  - reset by rst_n.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
  - I=1000, Q=0, avg_log2=2, continuous valid -> power=1000000, valid_out every 4th cycle, first pulse 3 cycles after the 4th sample.
  - I=-32768, Q=-32768, avg_log2=8 -> power=2147483648 (0x80000000), no wrap.
  - avg_log2=0, I=3, Q=4 every cycle -> power=25 every cycle, 3-cycle latency.
  - avg_log2=1, samples (I,Q)=(1,0),(2,0) with 5 idle cycles between -> power=2 (5>>1), exactly one pulse.
  - avg_log2=3, clear after 5 samples, then 8 samples of (10,10) -> no pulse for the aborted window, then power=200; power held at prior value meanwhile.
  - rst_n pulsed low after 3 of 4 samples, and avg_log2 changed 2->1 mid-window in a separate run -> no pulse after reset, outputs 0; in the changed-window run the mid-window change is ignored until the next window.
